tl_ul_reg_bridge: RTL
=====================

Name: tl_ul_reg_bridge

Overview:
- Downstream consumer of the TileLink-UL peripheral-port widget stage. Terminates the 32-bit TL-UL A/D channel pair and drives a simple single-outstanding register request/acknowledge bus into peripheral register files.
- Checks opcode, size and alignment. Runs a watchdog on each register access. Always returns exactly one D beat per accepted A beat.

Parameters:
- ADDR_W, 32, A-channel address width and reg_addr width
- SRC_W, 8, TL source ID width
- SIZE_W, 2, TL size field width (log2 bytes)
- TIMEOUT, 255, cycles without reg_ack before the access is aborted with error; legal range 1..255

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  A beat valid
- a_ready  out  1  bridge can accept an A beat
- a_opcode  in  3  TL opcode: 0 PutFull, 1 PutPartial, 4 Get
- a_param  in  3  ignored; must be 0
- a_size  in  SIZE_W  log2 transfer bytes
- a_source  in  SRC_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte lanes
- a_data  in  32  write data
- d_valid  out  1  D beat valid
- d_ready  in  1  D consumer ready
- d_opcode  out  3  0 AccessAck, 1 AccessAckData
- d_size  out  SIZE_W  echoed a_size
- d_source  out  SRC_W  echoed a_source
- d_data  out  32  read data; 0 for writes and errors
- d_denied  out  1  request failed
- reg_req  out  1  register access strobe, held until ack
- reg_we  out  1  1 = write
- reg_addr  out  ADDR_W  word-aligned address (bits 1:0 forced 0)
- reg_wdata  out  32  write data
- reg_wmask  out  4  byte enables
- reg_ack  in  1  access complete, sampled while reg_req=1
- reg_rdata  in  32  read data, valid with reg_ack
- reg_err  in  1  slave error, valid with reg_ack

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state IDLE, d_valid=0, reg_req=0, a_ready=1, all data, ID and denied registers 0, timer 0.
- a_ready is 1 only in IDLE. A beat accepted on a_valid & a_ready.
- Request capture on acceptance: opcode, size, source, address, mask and data are registered.
- Legality check, performed on acceptance:
  - opcode must be in {0,1,4}
  - a_size must be <= 2
  - address must be aligned to 2^a_size
- Legal request: go to ACCESS the next cycle. reg_req=1 and reg_we=(opcode!=4). reg_* outputs are held stable until completion.
- Illegal request: go directly to RESP with d_denied=1 and d_data=0. No reg_req is issued.
- In ACCESS, the timer increments each cycle.
  - reg_ack=1: reg_req drops the next cycle. Capture d_data = reg_rdata (reads only), d_denied = reg_err, then go to RESP.
  - Timer reaches TIMEOUT without ack: reg_req drops, d_denied=1, d_data=0, go to RESP.
  - A reg_ack arriving in the same cycle the timer expires wins: it is treated as a normal completion.
- In RESP, d_valid=1 and all D fields are held stable until d_ready. On d_valid & d_ready, go to IDLE and clear the timer.
- D fields: d_opcode = 1 for Get (including denied Gets), 0 otherwise. d_size and d_source are echoed.
- Latency for a legal access with zero-wait ack: A accepted at cycle N, reg_req at N+1, ack at N+1, d_valid at N+2, a_ready again at N+3 given d_ready at N+2.
- Throughput: at most one transaction in flight. No A beat is accepted until the D handshake completes.
- A reg_ack with reg_req=0 is ignored.
- Reset asserted mid-transaction: all state returns to reset values in the next cycle. The response is dropped, and reg_req deasserts without waiting for ack.

Decomposition:
- Shared package tl_ul_pkg holds:
  - opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1
  - the state enum
  - a function legal_req(opcode, size, addr_lsbs)
- One sub-module, tl_ul_reg_timer: 8-bit saturating counter with clear, enable and expire output, compared against TIMEOUT.

Test Plan:
- Get addr 0x10, size 2, source 0x5A; slave acks next cycle with rdata 0xDEADBEEF -> one D beat: opcode 1, source 0x5A, data 0xDEADBEEF, denied 0; reg_we=0, reg_addr=0x10.
- PutPartial addr 0x21, size 0, mask 0x2, data 0x0000AB00 -> reg_we=1, reg_addr=0x20, wmask 0x2; D opcode 0, data 0, denied 0.
- Opcode 2 (Arithmetic), or Get with size 2 at addr 0x02 -> no reg_req pulse; D denied=1, data 0, correct opcode and source echoed.
- TIMEOUT=4 with slave never acking -> reg_req high for exactly 4 cycles, then D denied=1; a later ack while reg_req=0 produces no second D beat.
- d_ready held low 10 cycles during RESP, with a_valid=1 continuously -> D fields stable, a_ready=0 throughout; next A beat accepted the cycle after the D handshake.
- Reset pulsed while in ACCESS -> reg_req=0 and d_valid=0 the next cycle, a_ready=1; no D beat is emitted for the aborted request.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions for the register bridge: opcodes, FSM states, request legality.
// Legality covers opcode set, size <= 4 bytes and natural alignment of the byte address.
package tl_ul_pkg;

   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   // size arrives zero-extended so the function is independent of SIZE_W
   function automatic logic legal_req(input logic [2:0] opcode,
                                      input logic [7:0] size,
                                      input logic [1:0] addr_lsbs);
      logic op_ok;
      logic aligned;
      op_ok = (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET);
      case (size)
         8'd0:    aligned = 1'b1;
         8'd1:    aligned = ~addr_lsbs[0];
         8'd2:    aligned = (addr_lsbs == 2'b00);
         default: aligned = 1'b0;
      endcase
      return op_ok && aligned;
   endfunction

endpackage

// File: rtl/tl_ul_reg_timer.sv
// Access watchdog: 8-bit saturating counter, expires in the cycle the count would reach TIMEOUT.
// No handshake; cleared by i_clr, counts while i_en.
module tl_ul_reg_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [7:0] r_count;

   always_ff @(posedge clock) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   // TIMEOUT cycles of i_en, counting the current one
   assign o_expire = i_en && (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/tl_ul_reg_bridge.sv
// TL-UL A/D to single-outstanding reg req/ack bridge; zero-wait read: A at N, D valid at N+2.
// a_ready only in IDLE; D fields held until d_ready; reg_* held until ack or watchdog expiry.
module tl_ul_reg_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned SRC_W   = 8,
   parameter int unsigned SIZE_W  = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [2:0]        a_param,
   input  logic [SIZE_W-1:0] a_size,
   input  logic [SRC_W-1:0]  a_source,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [3:0]        a_mask,
   input  logic [31:0]       a_data,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [SIZE_W-1:0] d_size,
   output logic [SRC_W-1:0]  d_source,
   output logic [31:0]       d_data,
   output logic              d_denied,
   output logic              reg_req,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_wmask,
   input  logic              reg_ack,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_err
);
   import tl_ul_pkg::*;

   state_e              r_state, w_state_nxt;
   logic                w_legal, w_accept, w_ack, w_timeout, w_d_done, w_expire;
   logic [2:0]          r_opcode;
   logic [SIZE_W-1:0]   r_size;
   logic [SRC_W-1:0]    r_source;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_mask;
   logic [31:0]         r_wdata;
   logic [31:0]         r_d_data;
   logic                r_d_denied;
   logic                w_unused;

   assign w_legal = legal_req(a_opcode, 8'(a_size), a_address[1:0]);

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ack       = 1'b0;
      w_timeout   = 1'b0;
      w_d_done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (a_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            // an ack in the expiry cycle is a normal completion
            if (reg_ack) begin
               w_ack       = 1'b1;
               w_state_nxt = RESP;
            end else if (w_expire) begin
               w_timeout   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (d_ready) begin
               w_d_done    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_opcode   <= '0;
         r_size     <= '0;
         r_source   <= '0;
         r_addr     <= '0;
         r_mask     <= '0;
         r_wdata    <= '0;
         r_d_data   <= '0;
         r_d_denied <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opcode   <= a_opcode;
            r_size     <= a_size;
            r_source   <= a_source;
            r_addr     <= a_address;
            r_mask     <= a_mask;
            r_wdata    <= a_data;
            r_d_data   <= '0;
            r_d_denied <= ~w_legal;
         end
         if (w_ack) begin
            r_d_data   <= ((r_opcode == GET) && !reg_err) ? reg_rdata : 32'd0;
            r_d_denied <= reg_err;
         end else if (w_timeout) begin
            r_d_denied <= 1'b1;
         end
      end
   end

   tl_ul_reg_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .i_clr    (w_d_done),
      .i_en     (r_state == ACCESS),
      .o_expire (w_expire)
   );

   assign a_ready   = (r_state == IDLE);
   assign d_valid   = (r_state == RESP);
   assign reg_req   = (r_state == ACCESS);
   assign reg_we    = (r_opcode != GET);
   assign reg_addr  = {r_addr[ADDR_W-1:2], 2'b00};
   assign reg_wdata = r_wdata;
   assign reg_wmask = r_mask;
   assign d_opcode  = (r_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
   assign d_size    = r_size;
   assign d_source  = r_source;
   assign d_data    = r_d_data;
   assign d_denied  = r_d_denied;

   // a_param is ignored; address lsbs only matter for the legality check
   assign w_unused = ^{a_param, r_addr[1:0]};

endmodule
